line_window_gen: RTL and testbench

LINE_WINDOW_GEN -- requirements
Module: line_window_gen

---
 rtl/line_window_gen.sv | 129 ++++++++++++
 tb/tb_line_window_gen.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_window_gen.sv
// 3x3 sliding-window generator over a raster AXI-Stream image (two line buffers + column shift register).
// Latency: one cycle from accepting a qualifying pixel (row>=2, col>=2) to m_axis_tvalid.
// Backpressure: s_axis_tready = m_axis_tready || !m_axis_tvalid; a held window stalls input and stays stable.
//
// Ports:
//   aclk, aresetn          clock, asynchronous active-low reset
//   s_axis_tdata/tuser/tlast/tvalid/tready   pixel input (tuser = start of frame, tlast = end of line)
//   m_axis_tdata (9*P)     window, pixel (r,c) at [P*(3r+c) +: P], r=0 oldest line, c=0 leftmost
//   m_axis_tuser/tlast     first window of frame / last window of output line
//   m_axis_tvalid/tready   window output handshake
//   err_eol                sticky: accepted tlast disagreed with the column counter
module line_window_gen #(
  parameter int IMG_W            = 670,
  parameter int IMG_H            = 410,
  parameter int AXIS_TDATA_WIDTH = 8
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [AXIS_TDATA_WIDTH-1:0]     s_axis_tdata,
  input  logic                            s_axis_tuser,
  input  logic                            s_axis_tlast,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  output logic [9*AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic                            m_axis_tuser,
  output logic                            m_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            err_eol
);

  localparam int P  = AXIS_TDATA_WIDTH;
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  // Position of the next pixel to be accepted.
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;

  // r_lb_mid holds line row-1, r_lb_top holds line row-2.
  logic [P-1:0] r_lb_mid [IMG_W];
  logic [P-1:0] r_lb_top [IMG_W];

  // Two previous window columns; [0] = leftmost. Each column packs row offset r at [P*r +: P].
  logic [3*P-1:0] r_colsh [2];

  logic          w_acc;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic          w_last_col;
  logic          w_last_row;
  logic          w_qual;
  logic [P-1:0]  w_top;
  logic [P-1:0]  w_mid;
  logic [3*P-1:0] w_newcol;
  logic [9*P-1:0] w_win;

  assign s_axis_tready = m_axis_tready || !m_axis_tvalid;
  assign w_acc         = s_axis_tvalid && s_axis_tready;

  // Start-of-frame overrides the counters so a partial frame is simply abandoned.
  assign w_col      = s_axis_tuser ? '0 : r_col;
  assign w_row      = s_axis_tuser ? '0 : r_row;
  assign w_last_col = (w_col == CW'(IMG_W - 1));
  assign w_last_row = (w_row == RW'(IMG_H - 1));
  assign w_qual     = (w_row >= RW'(2)) && (w_col >= CW'(2));

  assign w_top    = r_lb_top[w_col];
  assign w_mid    = r_lb_mid[w_col];
  assign w_newcol = {s_axis_tdata, w_mid, w_top};

  always_comb begin
    w_win = '0;
    for (int r = 0; r < 3; r++) begin
      w_win[P*(3*r+0) +: P] = r_colsh[0][P*r +: P];
      w_win[P*(3*r+1) +: P] = r_colsh[1][P*r +: P];
      w_win[P*(3*r+2) +: P] = w_newcol[P*r +: P];
    end
  end

  // Storage path: no reset needed, the first window after reset only uses
  // locations written since the last (0,0).
  always_ff @(posedge aclk) begin
    if (w_acc) begin
      r_lb_top[w_col] <= w_mid;
      r_lb_mid[w_col] <= s_axis_tdata;
      r_colsh[0]      <= r_colsh[1];
      r_colsh[1]      <= w_newcol;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_col         <= '0;
      r_row         <= '0;
      err_eol       <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      if (w_acc) begin
        if (w_last_col) begin
          r_col <= '0;
          r_row <= w_last_row ? '0 : w_row + 1'b1;
        end else begin
          r_col <= w_col + 1'b1;
          r_row <= w_row;
        end
        // Counters follow the column count; tlast is only checked.
        if (s_axis_tlast != w_last_col) begin
          err_eol <= 1'b1;
        end
      end

      // Accept implies the output slot is free or draining this cycle,
      // so a new window can be loaded back-to-back.
      if (w_acc && w_qual) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= w_win;
        m_axis_tuser  <= (w_row == RW'(2)) && (w_col == CW'(2));
        m_axis_tlast  <= w_last_col;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_line_window_gen.sv
module tb_line_window_gen;

  localparam int W = 5;
  localparam int H = 4;
  localparam int P = 8;
  localparam logic [71:0] FIRST_WIN = 72'h16_15_14_0c_0b_0a_02_01_00;

  logic          aclk;
  logic          aresetn;
  logic [P-1:0]  s_tdata;
  logic          s_tuser, s_tlast, s_tvalid, s_tready;
  logic [9*P-1:0] m_tdata;
  logic          m_tuser, m_tlast, m_tvalid, m_tready;
  logic          err_eol;

  line_window_gen #(.IMG_W(W), .IMG_H(H), .AXIS_TDATA_WIDTH(P)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_tdata),
    .s_axis_tuser  (s_tuser),
    .s_axis_tlast  (s_tlast),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tuser  (m_tuser),
    .m_axis_tlast  (m_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .err_eol       (err_eol)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;

  // Reference model: image of the current frame plus expected-window queues.
  logic [7:0]  img [H][W];
  int          mr, mc;
  bit          exp_err;
  logic [71:0] q_dat [$];
  bit          q_usr [$];
  bit          q_lst [$];

  // Stimulus controls and per-test statistics.
  int          rdy_mode;   // 0 always, 1 toggle, 2 random, 3 stalled
  bit          gap_mode;
  bit          rnd_pix;
  int          win_cnt, usr_cnt, lst_cnt;
  logic [71:0] first_dat;
  bit          hold_pend;
  logic [71:0] hold_dat;

  task automatic chk(input logic [71:0] obs, input logic [71:0] exp, input string tag);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    win_cnt = 0; usr_cnt = 0; lst_cnt = 0; first_dat = '0;
  endtask

  task automatic model_accept(input logic [7:0] d, input bit u, input bit l);
    logic [71:0] w;
    if (u) begin mr = 0; mc = 0; end
    if (l != (mc == W-1)) exp_err = 1'b1;
    img[mr][mc] = d;
    if (mr >= 2 && mc >= 2) begin
      w = '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          w[8*(3*r+c) +: 8] = img[mr-2+r][mc-2+c];
      q_dat.push_back(w);
      q_usr.push_back(mr == 2 && mc == 2);
      q_lst.push_back(mc == W-1);
    end
    mc++;
    if (mc == W) begin
      mc = 0;
      mr = (mr == H-1) ? 0 : mr + 1;
    end
  endtask

  // One clock: inputs already driven at the falling edge; sample 1ns later.
  task automatic do_cycle(output bit acc);
    bit xfer;
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ~m_tready;
      2:       m_tready = 1'($urandom_range(0, 1));
      default: m_tready = 1'b0;
    endcase
    #1;
    chk(s_tready, m_tready || !m_tvalid, "s_tready");
    chk(err_eol, exp_err, "err_eol");
    if (hold_pend) begin
      chk(m_tvalid, 1'b1, "hold_vld");
      chk(m_tdata, hold_dat, "hold_dat");
    end
    acc  = s_tvalid && s_tready;
    xfer = m_tvalid && m_tready;
    if (xfer) begin
      if (q_dat.size() == 0) begin
        chk(m_tvalid, 1'b0, "spurious_win");
      end else begin
        chk(m_tdata, q_dat.pop_front(), "win_dat");
        chk(m_tuser, q_usr.pop_front(), "win_user");
        chk(m_tlast, q_lst.pop_front(), "win_last");
      end
      if (win_cnt == 0) first_dat = m_tdata;
      win_cnt++;
      if (m_tuser) usr_cnt++;
      if (m_tlast) lst_cnt++;
    end
    hold_pend = m_tvalid && !m_tready;
    hold_dat  = m_tdata;
    if (acc) model_accept(s_tdata, s_tuser, s_tlast);
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic send_pix(input logic [7:0] d, input bit u, input bit l);
    bit acc;
    int n;
    if (gap_mode && $urandom_range(0, 3) == 0) begin
      s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0; s_tdata = 8'($urandom);
      do_cycle(acc);
    end
    s_tvalid = 1'b1; s_tdata = d; s_tuser = u; s_tlast = l;
    n = 0;
    do begin
      do_cycle(acc);
      n++;
    end while (!acc && n < 100);
    if (!acc) chk(s_tready, 1'b1, "accept_timeout");
    s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
  endtask

  function automatic logic [7:0] pix(input int r, input int c);
    return rnd_pix ? 8'($urandom) : 8'(10*r + c);
  endfunction

  // Full frame; tlast at (bad_r,bad_c) is inverted when that position exists.
  task automatic send_frame(input int bad_r, input int bad_c);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        send_pix(pix(r, c), (r == 0 && c == 0), (c == W-1) ^ (r == bad_r && c == bad_c));
  endtask

  task automatic drain();
    bit acc;
    int n;
    int saved;
    saved = rdy_mode;
    if (rdy_mode == 3) rdy_mode = 0;
    s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
    n = 0;
    while ((q_dat.size() != 0 || m_tvalid) && n < 200) begin
      do_cycle(acc);
      n++;
    end
    chk(72'(q_dat.size()), 72'd0, "drain_queue");
    chk(m_tvalid, 1'b0, "drain_vld");
    rdy_mode = saved;
  endtask

  // Reset is applied at a falling edge and checked before any clock edge.
  task automatic do_reset();
    aresetn  = 1'b0;
    s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
    #1;
    chk(m_tvalid, 1'b0, "rst_vld");
    chk(m_tuser, 1'b0, "rst_user");
    chk(m_tlast, 1'b0, "rst_last");
    chk(m_tdata, 72'd0, "rst_dat");
    chk(err_eol, 1'b0, "rst_err");
    q_dat.delete(); q_usr.delete(); q_lst.delete();
    mr = 0; mc = 0; exp_err = 1'b0; hold_pend = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    #1;
    chk(s_tready, 1'b1, "rst_s_tready");
    @(negedge aclk);
  endtask

  initial begin
    int dr, dc;
    bit u, l;
    aresetn = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tuser = 1'b0; s_tlast = 1'b0;
    m_tready = 1'b1; rdy_mode = 0; gap_mode = 1'b0; rnd_pix = 1'b0;
    @(negedge aclk);
    do_reset();

    // Full frame, always ready.
    clear_stats();
    send_frame(-1, -1);
    drain();
    chk(72'(win_cnt), 72'd6, "f1_count");
    chk(72'(lst_cnt), 72'd2, "f1_last_count");
    chk(first_dat, FIRST_WIN, "f1_first");

    // Alternating ready: same windows, held data stable.
    rdy_mode = 1;
    clear_stats();
    send_frame(-1, -1);
    drain();
    chk(72'(win_cnt), 72'd6, "toggle_count");
    chk(first_dat, FIRST_WIN, "toggle_first");

    // Partial frame aborted by start-of-frame at (1,3).
    rdy_mode = 0;
    clear_stats();
    for (int c = 0; c < W; c++) send_pix(pix(0, c), c == 0, c == W-1);
    for (int c = 0; c < 3; c++) send_pix(pix(1, c), 1'b0, 1'b0);
    send_frame(-1, -1);
    drain();
    chk(72'(win_cnt), 72'd6, "sof_count");
    chk(first_dat, FIRST_WIN, "sof_first");

    // Premature tlast at (0,2): sticky error, windows unaffected.
    clear_stats();
    send_frame(0, 2);
    drain();
    chk(err_eol, 1'b1, "eol_set");
    chk(72'(win_cnt), 72'd6, "eol_count");
    send_frame(-1, -1);
    drain();
    chk(err_eol, 1'b1, "eol_sticky");

    // Reset while a window is held.
    rdy_mode = 3;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < ((r == 2) ? 3 : W); c++)
        send_pix(pix(r, c), (r == 0 && c == 0), c == W-1);
    s_tvalid = 1'b1; s_tdata = 8'hAA;
    begin
      bit acc;
      do_cycle(acc);
      chk(acc, 1'b0, "stall_no_accept");
    end
    chk(m_tvalid, 1'b1, "held_before_rst");
    do_reset();
    rdy_mode = 0;
    clear_stats();
    send_frame(-1, -1);
    drain();
    chk(72'(win_cnt), 72'd6, "post_rst_count");
    chk(first_dat, FIRST_WIN, "post_rst_first");

    // Two back-to-back frames, continuous valid.
    clear_stats();
    send_frame(-1, -1);
    send_frame(-1, -1);
    drain();
    chk(72'(win_cnt), 72'd12, "b2b_count");
    chk(72'(usr_cnt), 72'd2, "b2b_user_count");

    // Random pixels, gaps, backpressure, occasional aborts and bad tlast.
    rdy_mode = 2; gap_mode = 1'b1; rnd_pix = 1'b1;
    dr = 0; dc = 0;
    for (int i = 0; i < 300; i++) begin
      u = 1'b0;
      if ($urandom_range(0, 39) == 0) begin dr = 0; dc = 0; end
      if (dr == 0 && dc == 0) u = 1'b1;
      l = (dc == W-1);
      if ($urandom_range(0, 99) == 0) l = ~l;
      send_pix(pix(dr, dc), u, l);
      dc++;
      if (dc == W) begin dc = 0; dr = (dr == H-1) ? 0 : dr + 1; end
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
